instruction_issue: RTL and testbench

- Issue (IX) stage directly downstream of instruction decode.
- Holds the 32x32 integer register file and a per-register pending-write scoreboard.
- Checks each decoded instruction for RAW/WAW hazards and target-pipe availability, then dispatches it with its operands to exactly the execution pipe(s) named in exe_pipe.
- Asserts a stall back to ID while it cannot issue; ID must hold id_valid and id_ix_inf stable while stalled.

---
 rtl/instruction_issue.sv | 146 ++++++++++++++
 tb/tb_instruction_issue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_issue.sv
// Issue (IX) stage: integer register file, pending-write scoreboard,
// RAW/WAW hazard and pipe-availability checks, one-cycle registered dispatch.
//
// Handshake: ID presents id_valid/id_ix_inf. The instruction is accepted
// (fires) in any cycle where id_valid is high, no flush is in progress and
// ix_stall is low. While ix_stall is high, ID holds id_valid and id_ix_inf
// stable. Downstream, exe_ready[p] high means pipe p accepts whatever
// ix_valid[p] presents on the following cycle; ix_valid is a one-cycle pulse.

package instruction_issue_pkg;

    localparam int EXE_PIPE_ID_ALU = 0;
    localparam int EXE_PIPE_ID_MUL = 1;
    localparam int EXE_PIPE_ID_DIV = 2;
    localparam int EXE_PIPE_ID_LSU = 3;
    localparam int EXE_PIPE_W      = 4;

    // Decoded instruction from ID. Only a1, a2, rd, register_write and
    // exe_pipe are interpreted here; the rest passes through untouched.
    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           imm;
        logic [9:0]            funct;
        logic [4:0]            a1;
        logic [4:0]            a2;
        logic [4:0]            rd;
        logic                  register_write;
        logic [EXE_PIPE_W-1:0] exe_pipe;
    } id_ix_inf_t;

endpackage

module instruction_issue
    import instruction_issue_pkg::*;
#(
    parameter int NUM_PIPES = 4,
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_do_branch,
    input  logic                 id_valid,
    input  id_ix_inf_t           id_ix_inf,
    output logic                 ix_stall,
    input  logic                 wb_valid,
    input  logic                 wb_write_en,
    input  logic [4:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [NUM_PIPES-1:0] exe_ready,
    output logic [NUM_PIPES-1:0] ix_valid,
    output id_ix_inf_t           ix_inf,
    output logic [XLEN-1:0]      ix_rs1_data,
    output logic [XLEN-1:0]      ix_rs2_data,
    output logic [NUM_REGS-1:0]  sb_pending
);

    // Architectural state (register file deliberately has no reset)
    logic [XLEN-1:0]      rf_q [NUM_REGS];
    logic                 rf_we;

    // Registered outputs
    logic [NUM_PIPES-1:0] ix_valid_q,  ix_valid_d;
    id_ix_inf_t           ix_inf_q,    ix_inf_d;
    logic [XLEN-1:0]      ix_rs1_q,    ix_rs1_d;
    logic [XLEN-1:0]      ix_rs2_q,    ix_rs2_d;
    logic [NUM_REGS-1:0]  sb_q,        sb_d;

    // Hazard / fire terms
    logic [NUM_REGS-1:0]  clr;
    logic [NUM_REGS-1:0]  set;
    logic [NUM_REGS-1:0]  pend_eff;
    logic                 raw1, raw2, waw, pipe_ok, no_pipe, fire;

    // Operand read with same-cycle writeback bypass; x0 reads as zero
    function automatic logic [XLEN-1:0] read_op(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (a != 5'd0) begin
            if (wb_valid && wb_write_en && (wb_rd == a)) v = wb_data;
            else                                         v = rf_q[a];
        end
        return v;
    endfunction

    // Hazard detection, fire/stall decision and next-state of all flops
    always_comb begin
        clr      = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
        pend_eff = sb_q & ~clr;

        raw1    = (id_ix_inf.a1 != 5'd0) && pend_eff[id_ix_inf.a1];
        raw2    = (id_ix_inf.a2 != 5'd0) && pend_eff[id_ix_inf.a2];
        waw     = id_ix_inf.register_write && (id_ix_inf.rd != 5'd0) && pend_eff[id_ix_inf.rd];
        pipe_ok = &(exe_ready | ~id_ix_inf.exe_pipe);
        no_pipe = (id_ix_inf.exe_pipe == '0);

        // An instruction with no target pipe has nothing to wait for
        fire = id_valid && !wb_do_branch &&
               (no_pipe || (!raw1 && !raw2 && !waw && pipe_ok));
        ix_stall = id_valid && !wb_do_branch && !fire;

        set = '0;
        if (fire && !no_pipe && id_ix_inf.register_write && (id_ix_inf.rd != 5'd0))
            set = NUM_REGS'(1) << id_ix_inf.rd;

        // Set is applied after clear so a same-cycle new writer wins
        sb_d = pend_eff | set;

        ix_valid_d = fire ? id_ix_inf.exe_pipe : '0;
        ix_inf_d   = fire ? id_ix_inf : ix_inf_q;
        ix_rs1_d   = fire ? read_op(id_ix_inf.a1) : ix_rs1_q;
        ix_rs2_d   = fire ? read_op(id_ix_inf.a2) : ix_rs2_q;

        rf_we = wb_valid && wb_write_en && (wb_rd != 5'd0);
    end

    // Control state: dispatch pulse and scoreboard
    always_ff @(posedge clk) begin
        if (rst) begin
            ix_valid_q <= '0;
            sb_q       <= '0;
        end else begin
            ix_valid_q <= ix_valid_d;
            sb_q       <= sb_d;
        end
    end

    // Datapath registers: contents only meaningful alongside ix_valid
    always_ff @(posedge clk) begin
        ix_inf_q <= ix_inf_d;
        ix_rs1_q <= ix_rs1_d;
        ix_rs2_q <= ix_rs2_d;
    end

    // Register file write port from WB
    always_ff @(posedge clk) begin
        if (rf_we) rf_q[wb_rd] <= wb_data;
    end

    assign ix_valid    = ix_valid_q;
    assign ix_inf      = ix_inf_q;
    assign ix_rs1_data = ix_rs1_q;
    assign ix_rs2_data = ix_rs2_q;
    assign sb_pending  = sb_q;

endmodule

// File: tb/tb_instruction_issue.sv
// Directed testbench for instruction_issue.
module tb_instruction_issue;
  import instruction_issue_pkg::*;

  localparam logic [3:0] P_ALU  = 4'b0001;
  localparam logic [3:0] P_MUL  = 4'b0010;
  localparam logic [3:0] P_DIV  = 4'b0100;
  localparam logic [3:0] P_NONE = 4'b0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_do_branch;
  logic        id_valid;
  id_ix_inf_t  id_ix_inf;
  logic        ix_stall;
  logic        wb_valid;
  logic        wb_write_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  exe_ready;
  logic [3:0]  ix_valid;
  id_ix_inf_t  ix_inf;
  logic [31:0] ix_rs1_data;
  logic [31:0] ix_rs2_data;
  logic [31:0] sb_pending;

  always #5 clk = ~clk;

  instruction_issue dut (
    .clk          (clk),
    .rst          (rst),
    .wb_do_branch (wb_do_branch),
    .id_valid     (id_valid),
    .id_ix_inf    (id_ix_inf),
    .ix_stall     (ix_stall),
    .wb_valid     (wb_valid),
    .wb_write_en  (wb_write_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .exe_ready    (exe_ready),
    .ix_valid     (ix_valid),
    .ix_inf       (ix_inf),
    .ix_rs1_data  (ix_rs1_data),
    .ix_rs2_data  (ix_rs2_data),
    .sb_pending   (sb_pending)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic id_ix_inf_t mk(input logic [4:0] a1, input logic [4:0] a2,
                                    input logic [4:0] rd, input logic rw,
                                    input logic [3:0] pipe);
    id_ix_inf_t t;
    t                = '0;
    t.pc             = 32'h0000_1000;
    t.imm            = 32'd5;
    t.funct          = 10'h2a;
    t.a1             = a1;
    t.a2             = a2;
    t.rd             = rd;
    t.register_write = rw;
    t.exe_pipe       = pipe;
    return t;
  endfunction

  task automatic present(input id_ix_inf_t t);
    id_valid  = 1'b1;
    id_ix_inf = t;
  endtask

  task automatic idle();
    id_valid  = 1'b0;
    id_ix_inf = '0;
  endtask

  task automatic wb_set(input logic [4:0] rd, input logic [31:0] d, input logic we);
    wb_valid    = 1'b1;
    wb_write_en = we;
    wb_rd       = rd;
    wb_data     = d;
  endtask

  task automatic wb_off();
    wb_valid    = 1'b0;
    wb_write_en = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
  endtask

  // Complete an outstanding write in one cycle
  task automatic complete(input logic [4:0] rd, input logic [31:0] d);
    wb_set(rd, d, 1'b1);
    tick();
    wb_off();
  endtask

  // ---------------- stimulus + expected values ----------------
  initial begin
    rst          = 1'b1;
    wb_do_branch = 1'b0;
    exe_ready    = 4'hF;
    idle();
    wb_off();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_ix_valid", 64'(ix_valid), 64'h0);
    chk("reset_sb", 64'(sb_pending), 64'h0);
    chk("reset_stall", 64'(ix_stall), 64'h0);

    // Seed register values
    complete(5'd10, 32'h0000_AAAA);
    complete(5'd11, 32'h0000_5555);
    complete(5'd3,  32'h0000_0333);
    chk("seed_sb", 64'(sb_pending), 64'h0);

    // --- back-to-back independent ALU ops ---
    present(mk(5'd10, 5'd0, 5'd1, 1'b1, P_ALU));
    #1 chk("b2b_stall0", 64'(ix_stall), 64'h0);
    tick();
    chk("b2b_valid0", 64'(ix_valid), 64'h1);
    chk("b2b_rs1_0", 64'(ix_rs1_data), 64'hAAAA);
    chk("b2b_rd0", 64'(ix_inf.rd), 64'd1);
    chk("b2b_sb0", 64'(sb_pending), 64'h2);
    present(mk(5'd11, 5'd0, 5'd2, 1'b1, P_ALU));
    #1 chk("b2b_stall1", 64'(ix_stall), 64'h0);
    tick();
    chk("b2b_valid1", 64'(ix_valid), 64'h1);
    chk("b2b_rs1_1", 64'(ix_rs1_data), 64'h5555);
    chk("b2b_sb1", 64'(sb_pending), 64'h6);
    idle();
    tick();
    chk("b2b_valid_off", 64'(ix_valid), 64'h0);
    complete(5'd1, 32'h0000_0101);
    complete(5'd2, 32'h0000_0202);
    chk("b2b_sb_clear", 64'(sb_pending), 64'h0);

    // --- RAW on MUL result ---
    present(mk(5'd1, 5'd2, 5'd5, 1'b1, P_MUL));
    tick();
    chk("raw_mul_valid", 64'(ix_valid), 64'h2);
    chk("raw_mul_rs2", 64'(ix_rs2_data), 64'h202);
    chk("raw_mul_sb", 64'(sb_pending), 64'h20);
    present(mk(5'd5, 5'd0, 5'd6, 1'b1, P_ALU));
    for (int i = 0; i < 2; i++) begin
      #1 chk("raw_stall", 64'(ix_stall), 64'h1);
      tick();
      chk("raw_no_issue", 64'(ix_valid), 64'h0);
    end
    wb_set(5'd5, 32'h0000_1234, 1'b1);
    #1 chk("raw_release_stall", 64'(ix_stall), 64'h0);
    tick();
    wb_off();
    idle();
    chk("raw_issue_valid", 64'(ix_valid), 64'h1);
    chk("raw_bypass_rs1", 64'(ix_rs1_data), 64'h1234);
    chk("raw_sb", 64'(sb_pending), 64'h40);
    complete(5'd6, 32'h0000_0066);
    chk("raw_sb_clear", 64'(sb_pending), 64'h0);

    // --- WAW with same-cycle clear/set ---
    present(mk(5'd0, 5'd0, 5'd7, 1'b1, P_ALU));
    tick();
    chk("waw_sb_first", 64'(sb_pending), 64'h80);
    present(mk(5'd0, 5'd0, 5'd7, 1'b1, P_ALU));
    #1 chk("waw_stall", 64'(ix_stall), 64'h1);
    wb_set(5'd7, 32'h0000_0077, 1'b1);
    #1 chk("waw_clear_nostall", 64'(ix_stall), 64'h0);
    tick();
    wb_off();
    idle();
    chk("waw_valid", 64'(ix_valid), 64'h1);
    chk("waw_set_wins", 64'(sb_pending), 64'h80);
    complete(5'd7, 32'h0000_0078);
    chk("waw_sb_clear", 64'(sb_pending), 64'h0);

    // --- pipe backpressure on DIV ---
    exe_ready = 4'b1011;
    present(mk(5'd1, 5'd2, 5'd8, 1'b1, P_DIV));
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_stall", 64'(ix_stall), 64'h1);
      tick();
      chk("bp_no_issue", 64'(ix_valid), 64'h0);
      chk("bp_sb_idle", 64'(sb_pending), 64'h0);
    end
    exe_ready = 4'hF;
    #1 chk("bp_release", 64'(ix_stall), 64'h0);
    tick();
    idle();
    chk("bp_valid", 64'(ix_valid), 64'h4);
    chk("bp_rs1", 64'(ix_rs1_data), 64'h101);
    chk("bp_rs2", 64'(ix_rs2_data), 64'h202);
    chk("bp_sb", 64'(sb_pending), 64'h100);
    complete(5'd8, 32'h0000_0888);

    // --- multi-bit exe_pipe waits for every target ---
    exe_ready = 4'b0001;
    present(mk(5'd8, 5'd0, 5'd0, 1'b0, P_ALU | P_MUL));
    #1 chk("multi_stall", 64'(ix_stall), 64'h1);
    tick();
    chk("multi_wait", 64'(ix_valid), 64'h0);
    exe_ready = 4'hF;
    tick();
    idle();
    chk("multi_valid", 64'(ix_valid), 64'h3);
    chk("multi_rs1", 64'(ix_rs1_data), 64'h888);

    // --- flush drops the incoming instruction ---
    wb_do_branch = 1'b1;
    present(mk(5'd0, 5'd0, 5'd9, 1'b1, P_ALU));
    #1 chk("flush_stall", 64'(ix_stall), 64'h0);
    tick();
    wb_do_branch = 1'b0;
    idle();
    chk("flush_valid", 64'(ix_valid), 64'h0);
    chk("flush_sb", 64'(sb_pending), 64'h0);

    // Squashed completion clears pending without writing x3
    present(mk(5'd0, 5'd0, 5'd3, 1'b1, P_ALU));
    tick();
    idle();
    chk("squash_sb_set", 64'(sb_pending), 64'h8);
    wb_set(5'd3, 32'h0000_DEAD, 1'b0);
    tick();
    wb_off();
    chk("squash_sb_clear", 64'(sb_pending), 64'h0);
    present(mk(5'd3, 5'd0, 5'd0, 1'b0, P_ALU));
    tick();
    idle();
    chk("squash_x3_kept", 64'(ix_rs1_data), 64'h333);

    // --- x0 handling ---
    present(mk(5'd0, 5'd0, 5'd0, 1'b1, P_ALU));
    tick();
    chk("x0_sb", 64'(sb_pending), 64'h0);
    chk("x0_rs1", 64'(ix_rs1_data), 64'h0);
    wb_set(5'd0, 32'hFFFF_FFFF, 1'b1);
    present(mk(5'd0, 5'd0, 5'd0, 1'b0, P_ALU));
    tick();
    wb_off();
    chk("x0_no_bypass_rs1", 64'(ix_rs1_data), 64'h0);
    chk("x0_no_bypass_rs2", 64'(ix_rs2_data), 64'h0);
    tick();
    idle();
    chk("x0_after_wb", 64'(ix_rs1_data), 64'h0);

    // --- zero exe_pipe fires regardless of readiness/hazards ---
    present(mk(5'd0, 5'd0, 5'd4, 1'b1, P_ALU));
    tick();
    chk("nop_pre_sb", 64'(sb_pending), 64'h10);
    exe_ready = 4'h0;
    present(mk(5'd4, 5'd0, 5'd4, 1'b1, P_NONE));
    #1 chk("nop_stall", 64'(ix_stall), 64'h0);
    tick();
    idle();
    exe_ready = 4'hF;
    chk("nop_valid", 64'(ix_valid), 64'h0);
    chk("nop_sb", 64'(sb_pending), 64'h10);
    complete(5'd4, 32'h0000_0044);
    chk("final_sb", 64'(sb_pending), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
